// File: rtl/dvp_cam_tx_pkg.sv
// cam_pkg: shared states, pattern codes and sizing helpers for the DVP camera transmitter
package cam_pkg;
  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBL, S_VFP} cam_state_t;
  typedef enum logic [1:0] {PAT_CONST, PAT_HRAMP, PAT_BARS, PAT_XYXOR} pattern_t;
  localparam int BYTES_PER_PIX = 2;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int max4(input int a, input int b, input int c, input int d);
    int ab, cd;
    ab = a > b ? a : b;
    cd = c > d ? c : d;
    return ab > cd ? ab : cd;
  endfunction
endpackage

// File: rtl/dvp_cam_tx_if.sv
// dvp_cam_tx_if: DVP sensor bus (pclk, vsync, href, 8-bit data); master drives, slave samples
interface dvp_cam_tx_if;
  logic       pclk;
  logic       vsync;
  logic       href;
  logic [7:0] data;
  modport master (output pclk, vsync, href, data);
  modport slave  (input  pclk, vsync, href, data);
endinterface

// File: rtl/dvp_cam_tx_pattern_gen.sv
// dvp_pattern_gen: combinational test-pattern byte for pixel (x, y), hi_i selects the high byte
// Ports: pattern_i pattern code, x_i pixel column, y_i line, hi_i high-byte select, byte_o result
module dvp_pattern_gen
  import cam_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int XW    = 5,
  parameter int YW    = 4
) (
  input  pattern_t      pattern_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic          hi_i,
  output logic [7:0]    byte_o
);
  logic [7:0]  x8, y8;
  logic [2:0]  bar;
  logic [15:0] px;
  assign x8  = 8'(x_i);
  assign y8  = 8'(y_i);
  // Eight equal-width bars across the line; divisor is a constant.
  assign bar = 3'({x_i, 3'b000} / WIDTH);
  assign px  = pattern_i == PAT_CONST ? 16'h0102 :
               pattern_i == PAT_HRAMP ? {x8, y8} :
               pattern_i == PAT_BARS  ? {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}} :
                                        {8'h00, x8 ^ y8};
  assign byte_o = hi_i ? px[15:8] : px[7:0];
endmodule

// File: rtl/dvp_cam_tx.sv
// dvp_cam_tx: DVP (RGB565, 2 bytes/pixel) camera-sensor transmitter with blanking and test patterns
// Ports: clk block clock (pclk = clk/2), rst_n async active-low reset, en_i continuous frames,
//        start_i one-frame pulse, pattern_i pattern code, cam DVP bus master,
//        busy_o frame in progress, frame_done_o end-of-frame pulse, frame_cnt_o completed frames
module dvp_cam_tx
  import cam_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int HEIGHT = 16,
  parameter int VS_LEN = 20,
  parameter int VBP    = 40,
  parameter int HBLANK = 20,
  parameter int VFP    = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         start_i,
  input  logic [1:0]   pattern_i,
  dvp_cam_tx_if.master cam,
  output logic         busy_o,
  output logic         frame_done_o,
  output logic [15:0]  frame_cnt_o
);
  localparam int BPL = BYTES_PER_PIX * WIDTH;
  localparam int BW  = cnt_w(BPL);
  localparam int XW  = cnt_w(WIDTH);
  localparam int YW  = cnt_w(HEIGHT);
  localparam int DW  = cnt_w(max4(VS_LEN, VBP, HBLANK, VFP));
  cam_state_t    state_q, state_d;
  pattern_t      pat_q, pat_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [BW-1:0] bc_q, bc_d;
  logic [YW-1:0] y_q, y_d;
  logic          pclk_q, pend_q, pend_d, vsync_q, href_q, busy_q, done_q;
  logic          tick, dur_end, fin;
  logic [7:0]    data_q, byte_w;
  logic [15:0]   fcnt_q;
  // A tick is the clk edge on which pclk falls; all bus outputs move only then.
  assign tick    = pclk_q;
  assign dur_end = dur_q == (state_q == S_VSYNC ? DW'(VS_LEN - 1) :
                             state_q == S_VBP   ? DW'(VBP - 1)    :
                             state_q == S_HBL   ? DW'(HBLANK - 1) : DW'(VFP - 1));
  assign fin     = tick && state_q == S_VFP && dur_end;
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    bc_d    = bc_q;
    y_d     = y_q;
    dur_d   = dur_q;
    // start is only remembered while idle, so a pulse during a frame is dropped.
    pend_d  = pend_q | (start_i & (state_q == S_IDLE));
    if (tick) begin
      case (state_q)
        S_IDLE:  state_d = (pend_d | en_i) ? S_VSYNC : S_IDLE;
        S_VSYNC: state_d = dur_end ? S_VBP : S_VSYNC;
        S_VBP:   state_d = dur_end ? S_LINE : S_VBP;
        S_LINE: begin
          bc_d    = bc_q == BW'(BPL - 1) ? '0 : bc_q + 1'b1;
          state_d = bc_q != BW'(BPL - 1) ? S_LINE : y_q == YW'(HEIGHT - 1) ? S_VFP : S_HBL;
          y_d     = state_d == S_HBL ? y_q + 1'b1 : y_q;
        end
        S_HBL:   state_d = dur_end ? S_LINE : S_HBL;
        S_VFP:   state_d = dur_end ? (en_i ? S_VSYNC : S_IDLE) : S_VFP;
        default: state_d = S_IDLE;
      endcase
      dur_d = (state_d != state_q || state_q == S_IDLE || state_q == S_LINE) ? '0 : dur_q + 1'b1;
      if (state_d == S_VSYNC && state_q != S_VSYNC) begin
        pat_d  = pattern_t'(pattern_i);
        y_d    = '0;
        bc_d   = '0;
        pend_d = 1'b0;
      end
    end
  end
  // Byte for the position the FSM moves to on this tick, registered on the tick itself.
  dvp_pattern_gen #(.WIDTH(WIDTH), .XW(XW), .YW(YW)) u_pat (
    .pattern_i(pat_d),
    .x_i      (XW'(bc_d >> 1)),
    .y_i      (y_d),
    .hi_i     (~bc_d[0]),
    .byte_o   (byte_w)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q  <= 1'b1;
      state_q <= S_IDLE;
      pat_q   <= PAT_CONST;
      dur_q   <= '0;
      bc_q    <= '0;
      y_q     <= '0;
      pend_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= 16'h0000;
    end else begin
      pclk_q  <= ~pclk_q;
      state_q <= state_d;
      pat_q   <= pat_d;
      dur_q   <= dur_d;
      bc_q    <= bc_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      done_q  <= fin;
      fcnt_q  <= fcnt_q + 16'(fin);
      if (tick) begin
        vsync_q <= state_d == S_VSYNC;
        href_q  <= state_d == S_LINE;
        data_q  <= state_d == S_LINE ? byte_w : 8'h00;
        busy_q  <= state_d != S_IDLE;
      end
    end
  end
  assign cam.pclk     = pclk_q;
  assign cam.vsync    = vsync_q;
  assign cam.href     = href_q;
  assign cam.data     = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frame_cnt_o  = fcnt_q;
endmodule

// File: tb/tb_dvp_cam_tx.sv
// tb_dvp_cam_tx: directed self-checking bench for dvp_cam_tx (24x16 frames, default blanking)
module tb_dvp_cam_tx;
  localparam int W = 24, H = 16, VS = 20, GAP = 40, HBL = 20, FP = 40;
  localparam int FRAME_TICKS = VS + GAP + H * 2 * W + (H - 1) * HBL + FP;
  logic        clk = 1'b0, rst_n = 1'b0, en_i = 1'b0, start_i = 1'b0;
  logic [1:0]  pattern_i = 2'd0;
  logic        busy, frame_done;
  logic [15:0] frame_cnt;
  logic [7:0]  line5 [48];
  int          n_chk = 0, n_fail = 0, idle_n = 0;
  logic        busy_end = 1'b0;
  dvp_cam_tx_if bus ();
  dvp_cam_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .start_i     (start_i),
    .pattern_i   (pattern_i),
    .cam         (bus),
    .busy_o      (busy),
    .frame_done_o(frame_done),
    .frame_cnt_o (frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] exp_byte(input logic [1:0] p, input int x, input int y, input bit hi);
    logic [15:0] px;
    int b;
    b = (x * 8) / W;
    case (p)
      2'd0:    px = 16'h0102;
      2'd1:    px = {x[7:0], y[7:0]};
      2'd2:    px = {{5{b[2]}}, {6{b[1]}}, {5{b[0]}}};
      default: px = {8'h00, x[7:0] ^ y[7:0]};
    endcase
    return hi ? px[15:8] : px[7:0];
  endfunction
  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask
  // Watches one frame sampled at pclk high; act 1 switches pattern to BARS, 2 drops en, 3 pulses start.
  task automatic frame(input logic [1:0] pat, input int act_at, input int act);
    int ticks = 0, vs = 0, gap = -1, lines = 0, run = 0, bc = 0, y = 0;
    int bad_len = 0, bad_hbl = 0, bad_byte = 0, bad_dz = 0, bad_busy = 0;
    logic in_frame = 1'b0, prev_href = 1'b0, done = 1'b0;
    idle_n = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (start_i) start_i = 1'b0;
      if (frame_done) begin
        done = 1'b1;
        busy_end = busy;
      end else if (bus.pclk) begin
        if (bus.vsync) in_frame = 1'b1;
        if (!in_frame) idle_n++;
        else begin
          ticks++;
          if (ticks == act_at) begin
            if (act == 1) pattern_i = 2'd2;
            if (act == 2) en_i = 1'b0;
            if (act == 3) start_i = 1'b1;
          end
          if (!busy) bad_busy++;
          if (bus.vsync) vs++;
          if (bus.href) begin
            if (!prev_href) begin
              if (lines == 0) gap = run;
              else if (run != HBL) bad_hbl++;
              y = lines;
              lines++;
              bc = 0;
            end
            if (bus.data !== exp_byte(pat, bc >> 1, y, bc % 2 == 0)) bad_byte++;
            if (y == 5 && bc < 48) line5[bc] = bus.data;
            bc++;
            run = 0;
          end else begin
            if (prev_href && bc != 2 * W) bad_len++;
            if (bus.data !== 8'h00) bad_dz++;
            if (!bus.vsync) run++;
          end
          prev_href = bus.href;
        end
      end
    end
    chk("frame_done_seen", done, 1);
    chk("vsync_ticks", vs, VS);
    chk("vbp_ticks", gap, GAP);
    chk("href_lines", lines, H);
    chk("bad_line_len", bad_len, 0);
    chk("bad_hblank", bad_hbl, 0);
    chk("bad_bytes", bad_byte, 0);
    chk("data_not_zero_href_low", bad_dz, 0);
    chk("busy_low_in_frame", bad_busy, 0);
    chk("vfp_ticks", run, FP);
    chk("frame_ticks", ticks, FRAME_TICKS);
  endtask
  initial begin
    int hit;
    #12;
    chk("rst_pclk", bus.pclk, 1);
    chk("rst_vsync", bus.vsync, 0);
    chk("rst_href", bus.href, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_cnt", frame_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_no_vsync", bus.vsync, 0);
    pattern_i = 2'd0;
    pulse_start();
    frame(2'd0, 0, 0);
    chk("busy_after_single", busy_end, 0);
    chk("cnt_after_const", frame_cnt, 1);
    pattern_i = 2'd1;
    pulse_start();
    frame(2'd1, 0, 0);
    chk("hramp_y5_x7_hi", line5[14], 8'h07);
    chk("hramp_y5_x7_lo", line5[15], 8'h05);
    chk("cnt_after_hramp", frame_cnt, 2);
    pulse_start();
    hit = 0;
    for (int i = 0; i < 600 && hit == 0; i++) begin
      @(negedge clk);
      if (bus.href) hit = 1;
    end
    chk("href_before_reset", hit, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pclk", bus.pclk, 1);
    chk("midrst_vsync", bus.vsync, 0);
    chk("midrst_href", bus.href, 0);
    chk("midrst_data", bus.data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", frame_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_vsync", bus.vsync, 0);
    chk("post_rst_href", bus.href, 0);
    pattern_i = 2'd3;
    en_i = 1'b1;
    frame(2'd3, 0, 0);
    chk("en_f1_idle", idle_n <= 2, 1);
    chk("en_f1_busy_kept", busy_end, 1);
    frame(2'd3, 0, 0);
    chk("en_f2_no_gap", idle_n, 0);
    chk("en_f2_busy_kept", busy_end, 1);
    frame(2'd3, 500, 2);
    chk("en_f3_no_gap", idle_n, 0);
    chk("en_f3_busy_falls", busy_end, 0);
    chk("cnt_after_en", frame_cnt, 3);
    repeat (200) @(negedge clk);
    chk("en_off_idle_busy", busy, 0);
    chk("en_off_idle_vsync", bus.vsync, 0);
    pattern_i = 2'd0;
    pulse_start();
    frame(2'd0, 300, 3);
    repeat (200) @(negedge clk);
    chk("start_busy_ignored", busy, 0);
    chk("cnt_after_ignored", frame_cnt, 4);
    pulse_start();
    frame(2'd0, 300, 1);
    pulse_start();
    frame(2'd2, 0, 0);
    chk("bars_x0_hi", line5[0], 8'h00);
    chk("bars_x0_lo", line5[1], 8'h00);
    chk("bars_x23_hi", line5[46], 8'hFF);
    chk("bars_x23_lo", line5[47], 8'hFF);
    chk("cnt_final", frame_cnt, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
